// File: rtl/seq_delay_line_param.sv
// rtl/seq_delay_line_param.sv - parametrised register delay line with stall, clear, tap and occupancy count
module seq_delay_line_param #(
    parameter int                 WIDTH     = 8,
    parameter int                 DEPTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                CW        = $clog2(DEPTH + 1),
    localparam int                SW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic             in_val,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SW-1:0]    tap_sel,
    output logic             out_val,
    output logic [WIDTH-1:0] out_data,
    output logic             tap_val,
    output logic [WIDTH-1:0] tap_data,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [DEPTH-1:0] val_q;
    logic [DEPTH-1:0] val_d;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    always_comb begin
        val_d   = val_q;
        count_d = count_q;
        for (int i = 0; i < DEPTH; i++) begin
            data_d[i] = data_q[i];
        end
        if (clear) begin
            val_d   = '0;
            count_d = '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_d[i] = RESET_VAL;
            end
        end else if (en) begin
            data_d[0] = in_data;
            val_d[0]  = in_val;
            for (int i = 1; i < DEPTH; i++) begin
                data_d[i] = data_q[i-1];
                val_d[i]  = val_q[i-1];
            end
            // Modular arithmetic stays exact: a full line always has its last stage valid.
            count_d = count_q + CW'(in_val) - CW'(val_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RESET_VAL;
            end
        end else begin
            val_q   <= val_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= data_d[i];
            end
        end
    end

    assign out_val  = val_q[DEPTH-1];
    assign out_data = data_q[DEPTH-1];
    assign count    = count_q;

    generate
        if (DEPTH == 1) begin : g_single
            logic unused_tap_sel;
            assign unused_tap_sel = ^tap_sel;
            assign tap_val        = val_q[0];
            assign tap_data       = data_q[0];
        end else begin : g_multi
            // Out-of-range selects fall through to the reset pattern.
            always_comb begin
                tap_val  = 1'b0;
                tap_data = RESET_VAL;
                for (int i = 0; i < DEPTH; i++) begin
                    if (tap_sel == SW'(i)) begin
                        tap_val  = val_q[i];
                        tap_data = data_q[i];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_seq_delay_line_param.sv
// tb/tb_seq_delay_line_param.sv - directed self-checking bench for seq_delay_line_param
module tb_seq_delay_line_param;

    logic       clk;
    logic       reset;

    logic       en4, clear4, in_val4;
    logic [7:0] in_data4;
    logic [1:0] tap_sel4;
    logic       out_val4, tap_val4;
    logic [7:0] out_data4, tap_data4;
    logic [2:0] count4;

    logic       en3, clear3, in_val3;
    logic [7:0] in_data3;
    logic [1:0] tap_sel3;
    logic       out_val3, tap_val3;
    logic [7:0] out_data3, tap_data3;
    logic [1:0] count3;

    int n_checks;
    int n_fail;

    seq_delay_line_param #(.WIDTH(8), .DEPTH(4), .RESET_VAL(8'h00)) u_dut4 (
        .clk(clk), .reset(reset), .en(en4), .clear(clear4),
        .in_val(in_val4), .in_data(in_data4), .tap_sel(tap_sel4),
        .out_val(out_val4), .out_data(out_data4),
        .tap_val(tap_val4), .tap_data(tap_data4), .count(count4)
    );

    seq_delay_line_param #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h5A)) u_dut3 (
        .clk(clk), .reset(reset), .en(en3), .clear(clear3),
        .in_val(in_val3), .in_data(in_data3), .tap_sel(tap_sel3),
        .out_val(out_val3), .out_data(out_data3),
        .tap_val(tap_val3), .tap_data(tap_data3), .count(count3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic e, input logic v, input logic [7:0] d);
        en4 = e; in_val4 = v; in_data4 = d;
        step();
    endtask

    task automatic drive3(input logic e, input logic v, input logic [7:0] d);
        en3 = e; in_val3 = v; in_data3 = d;
        step();
    endtask

    logic [7:0] lat_in  [7];
    logic [7:0] lat_out [7];
    logic [2:0] lat_cnt [7];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset = 1'b1;
        en4 = 0; clear4 = 0; in_val4 = 0; in_data4 = 8'h00; tap_sel4 = 2'd0;
        en3 = 0; clear3 = 0; in_val3 = 0; in_data3 = 8'h00; tap_sel3 = 2'd0;
        step();
        step();

        check("rst_out_val",  {31'd0, out_val4}, 32'd0);
        check("rst_out_data", {24'd0, out_data4}, 32'h00);
        check("rst_count",    {29'd0, count4}, 32'd0);
        check("rst_tap_val",  {31'd0, tap_val4}, 32'd0);
        check("rst3_out_data", {24'd0, out_data3}, 32'h5A);
        tap_sel3 = 2'd3;
        #1;
        check("rst3_tap_oor_val",  {31'd0, tap_val3}, 32'd0);
        check("rst3_tap_oor_data", {24'd0, tap_data3}, 32'h5A);
        reset = 1'b0;
        step();

        // Latency: first sample emerges after the 4th edge; line stays full.
        lat_in  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        lat_out = '{8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        lat_cnt = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4};
        for (int i = 0; i < 7; i++) begin
            drive4(1'b1, 1'b1, lat_in[i]);
            check("lat_count",    {29'd0, count4}, {29'd0, lat_cnt[i]});
            check("lat_out_data", {24'd0, out_data4}, {24'd0, lat_out[i]});
            check("lat_out_val",  {31'd0, out_val4}, (i >= 3) ? 32'd1 : 32'd0);
        end
        tap_sel4 = 2'd0;
        #1;
        check("lat_tap0", {24'd0, tap_data4}, 32'h77);

        // Stall: line frozen, 0xFF never enters.
        for (int i = 0; i < 4; i++) drive4(1'b1, 1'b1, 8'hA0 + 8'(i));
        check("fill_out_data", {24'd0, out_data4}, 32'hA0);
        for (int i = 0; i < 3; i++) begin
            drive4(1'b0, 1'b1, 8'hFF);
            check("stall_out_data", {24'd0, out_data4}, 32'hA0);
            check("stall_count",    {29'd0, count4}, 32'd4);
            check("stall_tap0",     {24'd0, tap_data4}, 32'hA3);
        end
        drive4(1'b1, 1'b0, 8'h00);
        check("drain_out_data", {24'd0, out_data4}, 32'hA1);
        check("drain_count",    {29'd0, count4}, 32'd3);
        check("drain_tap0_val", {31'd0, tap_val4}, 32'd0);

        // Asynchronous reset mid-stream, observed before any clock edge.
        reset = 1'b1;
        #1;
        check("areset_out_val",  {31'd0, out_val4}, 32'd0);
        check("areset_out_data", {24'd0, out_data4}, 32'h00);
        check("areset_count",    {29'd0, count4}, 32'd0);
        #1;
        reset = 1'b0;
        step();

        // Bubbles travel with the data.
        drive4(1'b1, 1'b1, 8'h01);
        drive4(1'b1, 1'b0, 8'h02);
        drive4(1'b1, 1'b1, 8'h03);
        en4 = 1'b0;
        tap_sel4 = 2'd1;
        #1;
        check("bub_count",     {29'd0, count4}, 32'd2);
        check("bub_tap1_val",  {31'd0, tap_val4}, 32'd0);
        check("bub_tap1_data", {24'd0, tap_data4}, 32'h02);
        tap_sel4 = 2'd2;
        #1;
        check("bub_tap2_val",  {31'd0, tap_val4}, 32'd1);
        check("bub_tap2_data", {24'd0, tap_data4}, 32'h01);

        // Clear beats enable; 0x55 dropped.
        clear4 = 1'b1;
        drive4(1'b1, 1'b1, 8'h55);
        clear4 = 1'b0;
        tap_sel4 = 2'd0;
        #1;
        check("clr_count",     {29'd0, count4}, 32'd0);
        check("clr_tap0_val",  {31'd0, tap_val4}, 32'd0);
        check("clr_tap0_data", {24'd0, tap_data4}, 32'h00);
        check("clr_out_val",   {31'd0, out_val4}, 32'd0);
        drive4(1'b0, 1'b0, 8'h00);
        check("clr_hold_count", {29'd0, count4}, 32'd0);

        // DEPTH=3 with non-zero reset value and an unused tap index.
        drive3(1'b1, 1'b1, 8'hB1);
        drive3(1'b1, 1'b1, 8'hB2);
        drive3(1'b1, 1'b1, 8'hB3);
        check("d3_out_data", {24'd0, out_data3}, 32'hB1);
        check("d3_count",    {30'd0, count3}, 32'd3);
        check("d3_tap3_val",  {31'd0, tap_val3}, 32'd0);
        check("d3_tap3_data", {24'd0, tap_data3}, 32'h5A);
        tap_sel3 = 2'd2;
        #1;
        check("d3_tap2_data", {24'd0, tap_data3}, 32'hB1);
        tap_sel3 = 2'd0;
        drive3(1'b1, 1'b0, 8'h77);
        check("d3_inval_count", {30'd0, count3}, 32'd2);
        check("d3_inval_out",   {24'd0, out_data3}, 32'hB2);
        check("d3_inval_tap0",  {24'd0, tap_data3}, 32'h77);
        check("d3_inval_tapv",  {31'd0, tap_val3}, 32'd0);
        clear3 = 1'b1;
        drive3(1'b0, 1'b0, 8'h00);
        clear3 = 1'b0;
        check("d3_clr_out_data", {24'd0, out_data3}, 32'h5A);
        check("d3_clr_count",    {30'd0, count3}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
